sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: core-clock cycles per debounce sample tick (>=2).
REQ-002 SHALL have parameter N_SAMPLES, default 3: consecutive equal samples needed to accept a new level (>=2).
REQ-003 SHALL have parameter SW_W, default 32: switch bus width.
REQ-004 SHALL have port i_clk  input  1  single core clock; all state on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_io_sw  input  SW_W  raw, asynchronous board switches.
REQ-007 SHALL have port i_clr_change  input  1  one-cycle clear of o_change_mask, driven by the LSU on a store to the switch-status address.
REQ-008 SHALL have port o_io_sw  output  SW_W  debounced switch levels, fed to the core's io_sw_i load path.
REQ-009 SHALL have port o_sw_change  output  1  one-cycle pulse when any o_io_sw bit changes.
REQ-010 SHALL have port o_change_mask  output  SW_W  sticky per-bit "changed since last clear" flags.

Function
REQ-011 SHALL pass each i_io_sw bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL run a free-running prescaler 0..TICK_DIV-1, wrapping to 0; internal tick is high for the one cycle the prescaler equals TICK_DIV-1.
REQ-013 SHALL, on each tick only, shift every bit's synchronized value into that bit's N_SAMPLES-deep history register.
REQ-014 SHALL set o_io_sw[k] to 1 the cycle after history[k] becomes all-ones, to 0 the cycle after it becomes all-zeros, and hold otherwise.
REQ-015 SHALL ignore any glitch shorter than N_SAMPLES ticks; mixed histories never change o_io_sw.
REQ-016 SHALL produce acceptance latency, from a raw step stable thereafter, between 2+(N_SAMPLES-1)*TICK_DIV+1 and 2+N_SAMPLES*TICK_DIV+1 cycles.
REQ-017 SHALL assert o_sw_change for exactly the cycle in which o_io_sw shows a new value; multiple bits changing together give one pulse.
REQ-018 SHALL set o_change_mask[k] in the same cycle o_io_sw[k] changes, holding until i_clr_change.
REQ-019 SHALL give set priority over clear when a bit changes in the same cycle i_clr_change is high (bit ends 1; other bits clear).
REQ-020 SHALL treat each bit independently; no bit's history affects another.

Reset
REQ-021 SHALL, while i_rst is high, immediately force synchronizers, histories, prescaler, o_io_sw, o_change_mask to 0 and o_sw_change to 0.
REQ-022 SHALL, on reset mid-debounce, discard partial histories; after release, switches already high are accepted as a normal 0->1 change (pulse plus mask set).

Configuration
REQ-023 SHALL compile debounce logic only when SW_DEBOUNCE_EN is defined; with it, REQ-012..REQ-016 apply.
REQ-024 SHALL, without SW_DEBOUNCE_EN, drive o_io_sw from the synchronizer output registered once (latency 3 cycles), omit prescaler and histories, keep REQ-017..REQ-019 unchanged.

Structure
REQ-025 SHALL place default TICK_DIV, N_SAMPLES, SW_W and the switch-status address constant in the shared io package.
REQ-026 SHALL use one sub-module, sw_debounce_bit (synchronizer + history + level register for one bit), instantiated SW_W times by generate.

Verification
REQ-027 SHALL verify reset: i_rst=1 with i_io_sw=32'hFFFF_FFFF -> o_io_sw=0, o_change_mask=0, o_sw_change=0 while reset held.
REQ-028 SHALL verify acceptance: defaults, i_io_sw 0 -> 32'h0000_0005 held -> o_io_sw=32'h5 within 11..15 cycles, single o_sw_change pulse, o_change_mask=32'h5.
REQ-029 SHALL verify glitch rejection: bit 3 high for 6 cycles (< 3 ticks) then low -> o_io_sw[3] stays 0, no pulse, mask unchanged.
REQ-030 SHALL verify clear/set race: i_clr_change=1 in the exact cycle bit 0 changes, bit 2 previously set -> mask bit0=1, bit2=0.
REQ-031 SHALL verify reset mid-operation: assert i_rst 5 cycles after raising bit 7, release, hold bit 7 -> accepted once with latency per REQ-016 after release.
REQ-032 SHALL verify config-off build (no SW_DEBOUNCE_EN): i_io_sw 0 -> 32'h1 -> o_io_sw=32'h1 exactly 3 cycles later, one o_sw_change pulse.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared io package for the switch input block: default sizing of the
// debouncer and the LSU address of the switch-status (change mask) register.
package sw_debounce_pkg;

  localparam int          SW_TICK_DIV_DEF   = 4;
  localparam int          SW_N_SAMPLES_DEF  = 3;
  localparam int          SW_W_DEF          = 32;
  localparam logic [31:0] SW_STATUS_ADDR    = 32'h1000_0010;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, sample history and accepted level.
// With SW_DEBOUNCE_EN defined the level only moves when the history is
// unanimous; otherwise the level is the synchronizer output registered once.
// o_update is high in the cycle before o_level takes a new value, so the
// parent can register its change pulse and mask on the same edge.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int N_SAMPLES = SW_N_SAMPLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef SW_DEBOUNCE_EN
  input  logic i_tick,
`endif
  input  logic i_sw,
  output logic o_level,
  output logic o_update
);

  logic sync1;
  logic sync2;
  logic level_next;

  // Two-flop synchronizer for the raw asynchronous switch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_sw;
      sync2 <= sync1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [N_SAMPLES-1:0] hist;

  // Shift the synchronized value into the history on sample ticks only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hist <= '0;
    end else if (i_tick) begin
      hist <= {hist[N_SAMPLES-2:0], sync2};
    end
  end

  // Unanimous history moves the level; mixed history holds it.
  always_comb begin
    level_next = o_level;
    if (&hist) begin
      level_next = 1'b1;
    end else if (~|hist) begin
      level_next = 1'b0;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (N_SAMPLES == 0);

  // Without debouncing the level simply follows the synchronizer.
  always_comb begin
    level_next = sync2;
  end
`endif

  assign o_update = level_next ^ o_level;

  // Accepted level register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_level <= 1'b0;
    end else begin
      o_level <= level_next;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer for the core's io_sw_i load path.
// Optional feature macro: SW_DEBOUNCE_EN (prescaler + per-bit histories).
// Without it each bit is synchronized and registered once (3-cycle latency).
// o_sw_change pulses in the cycle o_io_sw shows a new value; o_change_mask
// is sticky per bit and cleared by i_clr_change, with set winning over clear.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int TICK_DIV  = SW_TICK_DIV_DEF,
  parameter int N_SAMPLES = SW_N_SAMPLES_DEF,
  parameter int SW_W      = SW_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [SW_W-1:0] i_io_sw,
  input  logic            i_clr_change,
  output logic [SW_W-1:0] o_io_sw,
  output logic            o_sw_change,
  output logic [SW_W-1:0] o_change_mask
);

  logic [SW_W-1:0] update;
  logic            change_q;
  logic [SW_W-1:0] mask_q;

`ifdef SW_DEBOUNCE_EN
  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  // Free-running sample prescaler, 0..TICK_DIV-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (TICK_DIV == 0);
`endif

  for (genvar k = 0; k < SW_W; k++) begin : g_bit
    sw_debounce_bit #(
      .N_SAMPLES (N_SAMPLES)
    ) u_bit (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
`ifdef SW_DEBOUNCE_EN
      .i_tick   (tick),
`endif
      .i_sw     (i_io_sw[k]),
      .o_level  (o_io_sw[k]),
      .o_update (update[k])
    );
  end

  // Change pulse and sticky mask update on the same edge as the levels.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      change_q <= 1'b0;
      mask_q   <= '0;
    end else begin
      change_q <= |update;
      mask_q   <= (i_clr_change ? '0 : mask_q) | update;
    end
  end

  assign o_sw_change   = change_q;
  assign o_change_mask = mask_q;

endmodule
